// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks an IMG_W x IMG_H frame in raster order and farms each pixel out to N_LANES ap_ctrl_hs trace cores.
// Latency: start rise -> first lane_start is 2 cycles; a HELD lane reaches the output slot 1 cycle later when the slot is free.
// Backpressure: out_ready low freezes the output slot, lanes then stay HELD and no new pixels issue once every lane is full.
module pixel_dispatcher #(
  parameter int IMG_W   = 128,
  parameter int IMG_H   = 128,
  parameter int COORD_W = 8,
  parameter int N_LANES = 2,
  parameter int PIX_W   = 24
) (
  input  logic                       clk,
  input  logic                       ap_rst,
  input  logic                       start,
  input  logic                       continuous,
  output logic [N_LANES-1:0]         lane_start,
  output logic [16*N_LANES-1:0]      lane_x,
  output logic [16*N_LANES-1:0]      lane_y,
  input  logic [N_LANES-1:0]         lane_ready,
  input  logic [N_LANES-1:0]         lane_done,
  input  logic [PIX_W*N_LANES-1:0]   lane_return,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_x,
  output logic [15:0]                out_y,
  output logic [PIX_W-1:0]           out_pix,
  output logic                       busy,
  output logic                       frame_done,
  output logic [2*COORD_W-1:0]       pix_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  typedef enum logic [1:0] {L_FREE, L_ISSUED, L_BUSY, L_HELD} lane_st_t;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

  // Top-level frame state and raster cursor
  state_t                 state_q;
  logic                   start_prev_q;
  logic [COORD_W-1:0]     x_q;
  logic [COORD_W-1:0]     y_q;

  // Output slot and frame bookkeeping
  logic                   out_valid_q;
  logic [COORD_W-1:0]     out_x_q;
  logic [COORD_W-1:0]     out_y_q;
  logic [PIX_W-1:0]       out_pix_q;
  logic                   frame_done_q;
  logic [2*COORD_W-1:0]   pix_count_q;

  // Per-lane tracking: handshake state, issued coordinates, captured result
  lane_st_t               lst_q   [N_LANES];
  logic [N_LANES-1:0]     lane_start_q;
  logic [COORD_W-1:0]     lx_q    [N_LANES];
  logic [COORD_W-1:0]     ly_q    [N_LANES];
  logic [PIX_W-1:0]       res_q   [N_LANES];

  logic                   start_rise;
  logic                   pop;
  logic                   slot_open;
  logic                   all_free;
  logic                   found_free;
  logic                   found_held;
  logic                   issue;
  logic                   load;
  logic                   last_pix;
  logic [N_LANES-1:0]     issue_gnt;
  logic [N_LANES-1:0]     load_gnt;
  logic [COORD_W-1:0]     sel_x;
  logic [COORD_W-1:0]     sel_y;
  logic [PIX_W-1:0]       sel_pix;

  assign start_rise = start & ~start_prev_q;
  assign pop        = out_valid_q & out_ready;
  // Slot may take a new result if empty or being drained this very cycle
  assign slot_open  = ~out_valid_q | out_ready;
  assign last_pix   = (x_q == X_LAST) && (y_q == Y_LAST);
  assign issue      = |issue_gnt;
  assign load       = |load_gnt;

  // Lowest-index FREE lane receives the next pixel; lowest-index HELD lane refills the output slot
  always_comb begin
    issue_gnt  = '0;
    load_gnt   = '0;
    all_free   = 1'b1;
    found_free = 1'b0;
    found_held = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_pix    = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (lst_q[i] != L_FREE) begin
        all_free = 1'b0;
      end
      if ((lst_q[i] == L_FREE) && !found_free && (state_q == S_RUN)) begin
        issue_gnt[i] = 1'b1;
        found_free   = 1'b1;
      end
      if ((lst_q[i] == L_HELD) && !found_held && slot_open) begin
        load_gnt[i] = 1'b1;
        found_held  = 1'b1;
        sel_x       = lx_q[i];
        sel_y       = ly_q[i];
        sel_pix     = res_q[i];
      end
    end
  end

  // Frame sequencing, raster cursor, output slot and accepted-result counter
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_pix_q    <= '0;
      frame_done_q <= 1'b0;
      pix_count_q  <= '0;
    end else begin
      start_prev_q <= start;
      frame_done_q <= 1'b0;

      if (load) begin
        out_valid_q <= 1'b1;
        out_x_q     <= sel_x;
        out_y_q     <= sel_y;
        out_pix_q   <= sel_pix;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end

      if (pop && (pix_count_q != '1)) begin
        pix_count_q <= pix_count_q + (2*COORD_W)'(1);
      end

      // Later assignments in the state case (frame restart) take priority over the count above
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_q     <= S_RUN;
            x_q         <= '0;
            y_q         <= '0;
            pix_count_q <= '0;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (last_pix) begin
              state_q <= S_DRAIN;
            end else if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + COORD_W'(1);
            end else begin
              x_q <= x_q + COORD_W'(1);
            end
          end
        end
        S_DRAIN: begin
          // Nothing in flight and the last result has left the slot
          if (all_free && !out_valid_q) begin
            frame_done_q <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            if (continuous) begin
              state_q     <= S_RUN;
              pix_count_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Per-lane handshake tracking: issue, ap_ready acceptance, ap_done capture, release to output slot
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      lane_start_q <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        lst_q[i] <= L_FREE;
        lx_q[i]  <= '0;
        ly_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        case (lst_q[i])
          L_FREE: begin
            if (issue_gnt[i]) begin
              lst_q[i]        <= L_ISSUED;
              lane_start_q[i] <= 1'b1;
              lx_q[i]         <= x_q;
              ly_q[i]         <= y_q;
            end
          end
          L_ISSUED: begin
            if (lane_ready[i]) begin
              lane_start_q[i] <= 1'b0;
              if (lane_done[i]) begin
                lst_q[i] <= L_HELD;
                res_q[i] <= lane_return[i*PIX_W +: PIX_W];
              end else begin
                lst_q[i] <= L_BUSY;
              end
            end
          end
          L_BUSY: begin
            if (lane_done[i]) begin
              lst_q[i] <= L_HELD;
              res_q[i] <= lane_return[i*PIX_W +: PIX_W];
            end
          end
          L_HELD: begin
            if (load_gnt[i]) begin
              lst_q[i] <= L_FREE;
            end
          end
          default: lst_q[i] <= L_FREE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane_out
    assign lane_x[16*g +: 16] = 16'(lx_q[g]);
    assign lane_y[16*g +: 16] = 16'(ly_q[g]);
  end

  assign lane_start = lane_start_q;
  assign out_valid  = out_valid_q;
  assign out_x      = 16'(out_x_q);
  assign out_y      = 16'(out_y_q);
  assign out_pix    = out_pix_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher: 4x2 frame, two modelled trace lanes, set-based scoreboard of expected pixels.
module tb_pixel_dispatcher;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NL   = 2;
  localparam int CW   = 8;
  localparam int PW   = 24;
  localparam int NPIX = W * H;

  logic                 clk = 1'b0;
  logic                 ap_rst;
  logic                 start;
  logic                 continuous;
  logic [NL-1:0]        lane_start;
  logic [16*NL-1:0]     lane_x;
  logic [16*NL-1:0]     lane_y;
  logic [NL-1:0]        lane_ready;
  logic [NL-1:0]        lane_done;
  logic [PW*NL-1:0]     lane_return;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_x;
  logic [15:0]          out_y;
  logic [PW-1:0]        out_pix;
  logic                 busy;
  logic                 frame_done;
  logic [2*CW-1:0]      pix_count;

  pixel_dispatcher #(
    .IMG_W(W), .IMG_H(H), .COORD_W(CW), .N_LANES(NL), .PIX_W(PW)
  ) dut (
    .clk(clk), .ap_rst(ap_rst), .start(start), .continuous(continuous),
    .lane_start(lane_start), .lane_x(lane_x), .lane_y(lane_y),
    .lane_ready(lane_ready), .lane_done(lane_done), .lane_return(lane_return),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_pix(out_pix), .busy(busy), .frame_done(frame_done), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: which pixels of the current frame are still owed,
  // and the raster order in which pixels must be handed to lanes.
  bit pend [NPIX];
  int issue_q [$];
  int issued_cnt;
  int popped_frame;
  int frames;
  int last_idx;
  bit ooo_seen;

  // Lane model knobs and state
  int lat [NL];
  int rdly_max;
  int ph [NL];
  int rc [NL];
  int dc [NL];
  logic [7:0] cx [NL];
  logic [7:0] cy [NL];
  int lane_e;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void refill();
    issue_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      pend[i] = 1'b1;
      issue_q.push_back(i);
    end
    issued_cnt   = 0;
    popped_frame = 0;
    last_idx     = -1;
  endfunction

  function automatic logic [PW-1:0] pix_model(logic [15:0] x, logic [15:0] y);
    return {x[7:0], y[7:0], 8'h5A};
  endfunction

  // Lane models: accept on lane_start after rc cycles, complete lat cycles after ready (0 = same cycle)
  initial begin
    lane_ready  = '0;
    lane_done   = '0;
    lane_return = '0;
    for (int i = 0; i < NL; i++) ph[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      lane_ready = '0;
      lane_done  = '0;
      if (ap_rst !== 1'b0) begin
        for (int i = 0; i < NL; i++) ph[i] = 0;
        continue;
      end
      for (int i = 0; i < NL; i++) begin
        if (ph[i] == 0 && lane_start[i] === 1'b1) begin
          cx[i] = lane_x[16*i +: 8];
          cy[i] = lane_y[16*i +: 8];
          ph[i] = 1;
          rc[i] = (rdly_max > 0) ? $urandom_range(rdly_max, 0) : 0;
          issued_cnt++;
          if (issue_q.size() == 0) begin
            chk("issue_extra", 64'd1, 64'd0);
          end else begin
            lane_e = issue_q.pop_front();
            chk("issue_xy", {lane_x[16*i +: 16], lane_y[16*i +: 16]},
                {16'(lane_e % W), 16'(lane_e / W)});
          end
        end
        if (ph[i] == 1) begin
          if (rc[i] == 0) begin
            lane_ready[i] = 1'b1;
            if (lat[i] == 0) begin
              lane_done[i] = 1'b1;
              lane_return[PW*i +: PW] = {cx[i], cy[i], 8'h5A};
              ph[i] = 0;
            end else begin
              ph[i] = 2;
              dc[i] = lat[i];
            end
          end else begin
            rc[i]--;
          end
        end else if (ph[i] == 2) begin
          dc[i]--;
          if (dc[i] == 0) begin
            lane_done[i] = 1'b1;
            lane_return[PW*i +: PW] = {cx[i], cy[i], 8'h5A};
            ph[i] = 0;
          end
        end
      end
    end
  end

  // Monitor: sampled on the falling edge, checks every accepted result and every frame end
  logic            stall_prev;
  logic            fd_prev;
  logic [15:0]     hx;
  logic [15:0]     hy;
  logic [PW-1:0]   hp;
  logic [2*CW-1:0] pc_prev;
  int              mon_idx;
  int              missing;

  initial begin
    stall_prev = 1'b0;
    fd_prev    = 1'b0;
    pc_prev    = '0;
    frames     = 0;
    forever begin
      @(negedge clk);
      if (ap_rst !== 1'b0) begin
        stall_prev = 1'b0;
        fd_prev    = 1'b0;
        continue;
      end
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", {out_x, out_y, out_pix}, {hx, hy, hp});
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        popped_frame++;
        chk("pop_range", 64'((out_x < W) && (out_y < H)), 64'd1);
        if ((out_x < W) && (out_y < H)) begin
          mon_idx = int'(out_y) * W + int'(out_x);
          chk("pop_unique", 64'(pend[mon_idx]), 64'd1);
          pend[mon_idx] = 1'b0;
          chk("pop_pix", 64'(out_pix), 64'(pix_model(out_x, out_y)));
          if (mon_idx < last_idx) ooo_seen = 1'b1;
          last_idx = mon_idx;
        end
      end
      if (frame_done === 1'b1) begin
        chk("frame_done_width", 64'(fd_prev), 64'd0);
        chk("frame_results", 64'(popped_frame), 64'(NPIX));
        chk("frame_pix_count", 64'(pc_prev), 64'(NPIX));
        missing = 0;
        for (int i = 0; i < NPIX; i++) if (pend[i]) missing++;
        chk("frame_missing", 64'(missing), 64'd0);
        frames++;
        refill();
      end
      fd_prev    = frame_done;
      pc_prev    = pix_count;
      stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
      hx = out_x;
      hy = out_y;
      hp = out_pix;
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until(int n, int budget, bit rnd);
    int c = 0;
    while (frames < n && c < budget) begin
      step();
      if (rnd) out_ready = 1'($urandom_range(1, 0));
      c++;
    end
    chk("frame_timeout", 64'(frames >= n), 64'd1);
  endtask

  int c;
  int bad;

  initial begin
    ap_rst     = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    out_ready  = 1'b1;
    lat        = '{5, 5};
    rdly_max   = 0;
    ooo_seen   = 1'b0;
    refill();
    repeat (3) @(posedge clk);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_lane_start", 64'(lane_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_pix_count", 64'(pix_count), 64'd0);
    chk("rst_lane_x", 64'(lane_x), 64'd0);
    chk("rst_out_pix", 64'(out_pix), 64'd0);
    ap_rst = 1'b0;
    step();

    // Basic frame, start latency
    refill();
    start = 1'b1;
    step();
    chk("latency_c1_lane_start", 64'(lane_start), 64'd0);
    chk("latency_c1_busy", 64'(busy), 64'd1);
    step();
    chk("latency_c2_lane_start", 64'(lane_start), 64'd1);
    start = 1'b0;
    run_until(1, 400, 1'b0);
    repeat (2) step();
    chk("f1_busy_after", 64'(busy), 64'd0);
    chk("f1_frames", 64'(frames), 64'd1);

    // Uneven lane latencies give out-of-raster completion
    lat = '{20, 3};
    ooo_seen = 1'b0;
    refill();
    pulse_start();
    run_until(2, 600, 1'b0);
    chk("f2_out_of_order", 64'(ooo_seen), 64'd1);

    // Long sink stall mid-frame, then random backpressure
    lat = '{5, 5};
    refill();
    pulse_start();
    c = 0;
    while (popped_frame < 2 && c < 100) begin step(); c++; end
    chk("f3_two_pops", 64'(popped_frame >= 2), 64'd1);
    out_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (k >= 15 && lane_start !== '0) bad++;
    end
    chk("f3_stall_no_issue", 64'(bad), 64'd0);
    chk("f3_stall_valid", 64'(out_valid), 64'd1);
    run_until(3, 2000, 1'b1);
    out_ready = 1'b1;
    repeat (2) step();

    // ready and done in the same cycle, random accept delay
    lat = '{0, 0};
    rdly_max = 2;
    refill();
    pulse_start();
    run_until(4, 1000, 1'b1);
    out_ready = 1'b1;
    repeat (2) step();

    // Continuous re-render with spurious start pulses
    for (int i = 0; i < NL; i++) lat[i] = $urandom_range(8, 1);
    rdly_max = 1;
    refill();
    continuous = 1'b1;
    pulse_start();
    c = 0;
    while (frames < 5 && c < 1000) begin
      step();
      start = 1'($urandom_range(1, 0));
      c++;
    end
    chk("cont_first_done", 64'(frames), 64'd5);
    continuous = 1'b0;
    start = 1'b0;
    chk("cont_restart_busy", 64'(busy), 64'd1);
    run_until(6, 1000, 1'b0);
    repeat (2) step();
    chk("cont_busy_after", 64'(busy), 64'd0);

    // Reset while draining with a result waiting in the slot
    lat = '{5, 5};
    rdly_max = 0;
    refill();
    out_ready = 1'b1;
    pulse_start();
    c = 0;
    while (issued_cnt < NPIX && c < 200) begin step(); c++; end
    chk("drain_all_issued", 64'(issued_cnt), 64'(NPIX));
    out_ready = 1'b0;
    c = 0;
    while (out_valid !== 1'b1 && c < 50) begin step(); c++; end
    chk("drain_valid", 64'(out_valid), 64'd1);
    chk("drain_busy", 64'(busy), 64'd1);
    ap_rst = 1'b1;
    step();
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_lane_start", 64'(lane_start), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_pix_count", 64'(pix_count), 64'd0);
    chk("arst_frames", 64'(frames), 64'd6);
    ap_rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("arst_stays_idle", 64'(busy), 64'd0);

    // Clean frame after the mid-frame reset
    for (int i = 0; i < NL; i++) lat[i] = $urandom_range(6, 1);
    refill();
    pulse_start();
    run_until(7, 1000, 1'b1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("final_busy", 64'(busy), 64'd0);
    chk("final_frames", 64'(frames), 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
